// File: rtl/i2c_pkg.sv
// i2c_pkg
//   Shared definitions for the I2C responder: the protocol state
//   enumeration, R/W bit values and ACK/NACK line levels.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        WAIT_STOP
    } i2c_state_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter
//   Conditions one asynchronous open-drain bus line: two-flop synchroniser
//   followed by a 3-sample majority vote, so single-cycle glitches never
//   reach the protocol logic.
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset (line assumed idle-high)
//   line_raw asynchronous bus level
//   level    filtered level
//   rise     one-cycle pulse when the filtered level goes 0 -> 1
//   fall     one-cycle pulse when the filtered level goes 1 -> 0
module i2c_line_filter (
    input  logic clk,
    input  logic rst,
    input  logic line_raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic       sync_p0;
    logic       sync_p1;
    logic [2:0] hist;
    logic       level_q;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // Flops reset to the idle-high bus level so leaving reset never
    // produces a spurious edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            hist    <= 3'b111;
            level_q <= 1'b1;
        end else begin
            sync_p0 <= line_raw;
            sync_p1 <= sync_p0;
            hist    <= {hist[1:0], sync_p1};
            level_q <= level;
        end
    end

    assign level = majority3(hist);
    assign rise  = level & ~level_q;
    assign fall  = ~level & level_q;

endmodule

// File: rtl/i2c_responder.sv
// i2c_responder
//   I2C target giving a bus master read/write access to a small external
//   register bank through a byte pointer that auto-increments.
//   Write frame: START, addr+W, pointer, data..., STOP.
//   Read frame:  START, addr+W, pointer, Sr, addr+R, data..., STOP.
// Ports:
//   clk      system clock (>= 16x SCL)
//   rst      asynchronous active-high reset
//   scl_i    bus SCL (async)
//   sda_i    bus SDA (async)
//   sda_t    SDA tristate: 0 = pull low, 1 = release
//   scl_t    SCL tristate, always released (no clock stretching)
//   wr_en    one-cycle register write strobe
//   wr_addr  register index of the write
//   wr_data  register write data
//   rd_addr  current register pointer
//   rd_data  register contents at rd_addr (valid within one cycle)
//   busy     high from an address match until STOP
module i2c_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h3C,
    parameter int         PTR_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_t,
    output logic             scl_t,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic [PTR_W-1:0] rd_addr,
    input  logic [7:0]       rd_data,
    output logic             busy
);
    import i2c_pkg::*;

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_state_t       state, state_nxt;
    logic [3:0]       bit_cnt, bit_cnt_nxt;
    logic [6:0]       shreg, shreg_nxt;
    logic [7:0]       tx_byte, tx_nxt;
    logic [7:0]       rx_byte;
    logic             rw, rw_nxt;
    logic             sda_t_nxt, wr_en_nxt, busy_nxt;
    logic [PTR_W-1:0] rd_addr_nxt, wr_addr_nxt;
    logic [7:0]       wr_data_nxt;

    i2c_line_filter u_scl_filt (
        .clk      (clk),
        .rst      (rst),
        .line_raw (scl_i),
        .level    (scl_lvl),
        .rise     (scl_rise),
        .fall     (scl_fall)
    );

    i2c_line_filter u_sda_filt (
        .clk      (clk),
        .rst      (rst),
        .line_raw (sda_i),
        .level    (sda_lvl),
        .rise     (sda_rise),
        .fall     (sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign scl_t     = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            tx_byte <= '1;
            rw      <= I2C_RW_WRITE;
            sda_t   <= 1'b1;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            rd_addr <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            tx_byte <= tx_nxt;
            rw      <= rw_nxt;
            sda_t   <= sda_t_nxt;
            wr_en   <= wr_en_nxt;
            wr_addr <= wr_addr_nxt;
            wr_data <= wr_data_nxt;
            rd_addr <= rd_addr_nxt;
            busy    <= busy_nxt;
        end
    end

    // bit_cnt counts SCL rising edges within a byte. In the ACK states it
    // is 8 before the 9th clock and 9 after it, which separates the falling
    // edge that starts the ACK slot from the one that ends it.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        tx_nxt      = tx_byte;
        rw_nxt      = rw;
        sda_t_nxt   = sda_t;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
        rd_addr_nxt = rd_addr;
        busy_nxt    = busy;
        rx_byte     = {shreg, sda_lvl};

        if (stop_det) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            sda_t_nxt = 1'b1;
        end else if (start_det) begin
            state_nxt   = ADDR;
            bit_cnt_nxt = '0;
            sda_t_nxt   = 1'b1;
        end else begin
            case (state)
                IDLE, WAIT_STOP: sda_t_nxt = 1'b1;

                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shreg_nxt   = rx_byte[6:0];
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (state == ADDR) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    busy_nxt  = 1'b1;
                                    rw_nxt    = rx_byte[0];
                                    state_nxt = ADDR_ACK;
                                end else begin
                                    state_nxt = WAIT_STOP;
                                end
                            end else if (state == PTR) begin
                                rd_addr_nxt = rx_byte[PTR_W-1:0];
                                state_nxt   = PTR_ACK;
                            end else begin
                                wr_en_nxt   = 1'b1;
                                wr_addr_nxt = rd_addr;
                                wr_data_nxt = rx_byte;
                                rd_addr_nxt = rd_addr + PTR_W'(1);
                                state_nxt   = WDATA_ACK;
                            end
                        end
                    end
                end

                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_rise && bit_cnt == 4'd8)
                        bit_cnt_nxt = 4'd9;
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_t_nxt = ACK;
                        end else if (bit_cnt == 4'd9) begin
                            bit_cnt_nxt = '0;
                            if (state == ADDR_ACK && rw == I2C_RW_READ) begin
                                state_nxt = RDATA;
                                sda_t_nxt = rd_data[7];
                                tx_nxt    = {rd_data[6:0], 1'b1};
                            end else begin
                                sda_t_nxt = 1'b1;
                                state_nxt = (state == ADDR_ACK) ? PTR : WDATA;
                            end
                        end
                    end
                end

                RDATA: begin
                    if (scl_rise)
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_t_nxt = 1'b1;
                            state_nxt = RDATA_ACK;
                        end else begin
                            sda_t_nxt = tx_byte[7];
                            tx_nxt    = {tx_byte[6:0], 1'b1};
                        end
                    end
                end

                // The pointer advances on the master's ACK so rd_data has
                // settled by the falling edge that loads the next byte.
                RDATA_ACK: begin
                    if (scl_rise && bit_cnt == 4'd8) begin
                        if (sda_lvl == ACK) begin
                            rd_addr_nxt = rd_addr + PTR_W'(1);
                            bit_cnt_nxt = 4'd9;
                        end else begin
                            state_nxt = WAIT_STOP;
                        end
                    end
                    if (scl_fall && bit_cnt == 4'd9) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = RDATA;
                        sda_t_nxt   = rd_data[7];
                        tx_nxt      = {rd_data[6:0], 1'b1};
                    end
                end

                default: begin
                    state_nxt = IDLE;
                    sda_t_nxt = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/i2c_responder.md
Name: i2c_responder

Overview:
- I2C target (responder) for the board I2C bus; it is the other end of the i2c_sender master protocol.
- Lets an external master, or a second i2c_sender instance in the bench, read and write a small bank of core control registers (e.g. video offsets, audio gain).
- Sits beside the bus tristate logic in the top level: samples scl_i/sda_i, pulls SDA low via sda_t.
- Register storage is external; the block issues a write strobe and a read address.

Parameters:
- DEV_ADDR, 7'h3C, 7-bit target address matched after START.
- PTR_W, 4, width of register pointer (2^PTR_W registers).

Ports:
- clk  in  1  system clock (clk_28 domain), at least 16x SCL rate.
- rst  in  1  reset, asynchronous, active-high.
- scl_i  in  1  bus SCL, asynchronous.
- sda_i  in  1  bus SDA, asynchronous.
- sda_t  out  1  SDA tristate: 0 = drive low, 1 = release.
- scl_t  out  1  SCL tristate; tied 1 (no clock stretching).
- wr_en  out  1  one-cycle write strobe.
- wr_addr  out  PTR_W  register index for the write.
- wr_data  out  8  data for the write.
- rd_addr  out  PTR_W  current pointer; rd_data must be valid combinationally or within 1 cycle.
- rd_data  in  8  register read data.
- busy  out  1  high from an address match until STOP.

Behaviour:
- Reset values: sda_t=1, scl_t=1, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, state IDLE. Reset mid-transfer releases SDA immediately (async).
- Input conditioning: 2-flop sync on each of scl_i and sda_i, then a 3-sample majority filter. Edge and condition detection uses only the filtered values.
- START: SDA falls while SCL high. Valid from any state, including repeated START. Action: bit counter=0, go to ADDR.
- STOP: SDA rises while SCL high. Valid from any state. Action: go to IDLE, busy=0, sda_t=1.
- Bit timing: shift in on SCL rising; change sda_t only on the clk after an SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- ADDR: collect 8 bits, MSB first.
  - Bits [7:1]==DEV_ADDR: busy=1, ADDR_ACK (drive SDA low for the 9th clock).
  - Otherwise: WAIT_STOP, no ACK.
- ADDR_ACK exit: on the SCL falling edge ending the 9th clock.
  - R/W=0: release SDA, go to PTR.
  - R/W=1: go to RDATA and drive the MSB of rd_data at pointer rd_addr.
- PTR: 8 bits received; the low PTR_W bits load rd_addr; ACK; go to WDATA.
- WDATA: 8 bits received; ACK is driven in WDATA_ACK.
  - wr_en pulses for one clk on the SCL rising edge of bit 8, with wr_addr=rd_addr and wr_data=byte.
  - rd_addr then increments modulo 2^PTR_W (15 wraps to 0).
  - Further bytes repeat WDATA.
- RDATA: shift out 8 bits; the byte is latched from rd_data at the load edge. After bit 8, release SDA and sample the master's ACK on the 9th SCL rising edge.
  - ACK (0): rd_addr increments, then the next byte loads.
  - NACK (1): go to WAIT_STOP.
- WAIT_STOP: SDA released; stays here until STOP or START.
- Never drive SDA while in IDLE or WAIT_STOP, or during a master ACK slot.
- A START arriving mid-byte aborts the byte; no wr_en is issued for the partial byte.
- The pointer persists across transactions; it is reset only by rst.

Decomposition:
- Shared package i2c_pkg holds:
  - state enumeration;
  - I2C_RW_READ/I2C_RW_WRITE constants;
  - ACK=0/NACK=1 constants.
- One natural sub-module, i2c_line_filter: sync + majority filter. It outputs the filtered level, rise and fall pulses. Instantiate it once for SCL and once for SDA.

Test Plan:
- Write: START, 0x78 (DEV_ADDR 0x3C, W), 0x05, 0xA5, STOP -> ACK on all 3 bytes; one wr_en with wr_addr=5, wr_data=0xA5; rd_addr=6 after.
- Burst write wrap: pointer 0x0F, data 0x11, 0x22 -> wr_en at addr 15 (0x11), then addr 0 (0x22); rd_addr=1.
- Read with repeated START: 0x78, 0x03, Sr, 0x79, read 2 bytes (master ACK then NACK), STOP; rd_data model = addr*0x10 -> SDA shows 0x30 then 0x40; WAIT_STOP then IDLE; busy falls at STOP.
- Address mismatch: START, 0x50 -> SDA never driven low for the whole frame; no wr_en; busy=0.
- Abort: rst asserted while driving an ACK low -> sda_t=1 within the same clk, outputs at reset values. Separately, START in the middle of a WDATA byte -> no wr_en for the partial byte, and the following address is decoded correctly.
- Glitch: 1-clk low pulse on SCL during a data bit -> ignored; received byte unchanged.
